// File: rtl/mutex_arbiter_pkg.sv
// Shared types and constants for the mutex arbiter: FSM states, mutex slave
// register addresses and the owner/value field widths of the mutex word.
package mutex_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACQ_WR  = 3'd1,
        ACQ_RD  = 3'd2,
        OWNED   = 3'd3,
        REL_WR  = 3'd4,
        BACKOFF = 3'd5
    } state_t;

    localparam logic MUTEX_ADDR_VALUE = 1'b0;
    localparam logic MUTEX_ADDR_RESET = 1'b1;

    localparam int OWNER_W = 16;
    localparam int VALUE_W = 16;

endpackage

// File: rtl/mutex_arbiter_rr_picker.sv
// Combinational round-robin picker: the requester at ptr has top priority and
// the search wraps from N-1 back to 0.
module rr_picker #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     sel,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        idx      = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 0; off < N; off++) begin
            cand = int'(ptr) + off;
            if (cand >= N) cand = cand - N;
            cand_idx = IDX_W'(cand);
            if (!valid && req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
        sel = valid ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/mutex_arbiter.sv
// Arbitrates local requesters for a single hardware mutex: the winner's owner
// ID is written, read back to confirm ownership, and released by a value-0 write.
module mutex_arbiter
    import mutex_arbiter_pkg::*;
#(
    parameter int                 NUM_REQ        = 5,
    parameter logic [OWNER_W-1:0] OWNER_BASE     = 16'h0001,
    parameter logic [VALUE_W-1:0] LOCK_VALUE     = 16'h0001,
    parameter int                 BACKOFF_CYCLES = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] rel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy,
    output logic               m_address,
    output logic               m_chipselect,
    output logic               m_write,
    output logic               m_read,
    output logic [31:0]        m_writedata,
    input  logic [31:0]        m_readdata
);

    localparam int         IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] BACKOFF_LOAD = 8'(BACKOFF_CYCLES);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     cur_q, cur_d;
    logic [NUM_REQ-1:0]   cur_oh_q, cur_oh_d;
    logic [7:0]           cnt_q, cnt_d;

    logic [NUM_REQ-1:0]   pick_sel;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic [OWNER_W-1:0]   owner_id;
    logic [31:0]          lock_word;
    logic [IDX_W-1:0]     next_ptr;

    rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .sel   (pick_sel),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign owner_id  = OWNER_BASE + OWNER_W'(cur_q);
    assign lock_word = {owner_id, LOCK_VALUE};
    assign next_ptr  = (cur_q == IDX_W'(NUM_REQ - 1)) ? '0 : cur_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cur_q    <= '0;
            cur_oh_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cur_q    <= cur_d;
            cur_oh_q <= cur_oh_d;
            cnt_q    <= cnt_d;
        end
    end

    // Only rel of the current owner matters; req changes are ignored outside IDLE/BACKOFF.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_d    = cur_q;
        cur_oh_d = cur_oh_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    cur_d    = pick_idx;
                    cur_oh_d = pick_sel;
                    state_d  = ACQ_WR;
                end
            end
            ACQ_WR: state_d = ACQ_RD;
            ACQ_RD: begin
                if (m_readdata == lock_word) begin
                    state_d = OWNED;
                end else begin
                    cnt_d   = BACKOFF_LOAD;
                    state_d = BACKOFF;
                end
            end
            OWNED: begin
                if (|(rel & cur_oh_q)) state_d = REL_WR;
            end
            REL_WR: begin
                ptr_d   = next_ptr;
                state_d = IDLE;
            end
            BACKOFF: begin
                cnt_d = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
                if (!req[cur_q] || cnt_q <= 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt          = '0;
        busy         = (state_q != IDLE);
        m_address    = MUTEX_ADDR_VALUE;
        m_chipselect = 1'b0;
        m_write      = 1'b0;
        m_read       = 1'b0;
        m_writedata  = '0;
        unique case (state_q)
            ACQ_WR: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_writedata  = lock_word;
            end
            ACQ_RD: begin
                m_chipselect = 1'b1;
                m_read       = 1'b1;
            end
            OWNED: gnt = cur_oh_q;
            REL_WR: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_writedata  = {owner_id, VALUE_W'(0)};
            end
            default: ;
        endcase
    end

endmodule
